pe_result_writer: RTL and testbench

- Write-back end of the butterfly datapath. It takes the read-side issue stream (pair addresses plus valid) that feeds a PE, and delays it to match the fixed PE pipeline latency.
- It then writes bf_lower/bf_upper back to the coefficient memory through two write ports, one per butterfly operand.
- It counts completed butterflies per stage and signals stage completion to the stage controller.

---
 rtl/pe_result_writer_pkg.sv | 28 ++
 rtl/pe_result_writer_addr_delay_line.sv | 38 +++
 rtl/pe_result_writer.sv | 96 +++++++++
 tb/tb_pe_result_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_result_writer_pkg.sv
// Shared constants and delay-line entry type for the butterfly write-back path.
package pe_result_writer_pkg;

    localparam int data_width   = 14;
    localparam int addr_width   = 8;
    localparam int pe_lat       = 6;
    localparam int bf_per_stage = 256;
    localparam int cnt_width    = $clog2(bf_per_stage + 1);
    localparam int lat_width    = $clog2(pe_lat + 1);

    typedef struct packed {
        logic                  valid;
        logic [addr_width-1:0] addr_u;
        logic [addr_width-1:0] addr_v;
        logic                  mode;
    } delay_entry_t;

    // Number of occupied slots in the delay line.
    function automatic logic [lat_width-1:0] count_valid(input logic [pe_lat-1:0] bits);
        logic [lat_width-1:0] n;
        n = '0;
        for (int i = 0; i < pe_lat; i++) begin
            n = n + lat_width'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pe_result_writer_addr_delay_line.sv
// Free-running shift register carrying issue entries alongside the PE pipeline.
module addr_delay_line
    import pe_result_writer_pkg::*;
#(
    parameter int depth = pe_lat
) (
    input  logic               clk,
    input  logic               rst,
    input  delay_entry_t       din,
    output delay_entry_t       head,
    output logic [depth-1:0]   valids
);

    delay_entry_t stages [depth];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < depth; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign head = stages[depth-1];

    always_comb begin
        valids = '0;
        for (int i = 0; i < depth; i++) begin
            valids[i] = stages[i].valid;
        end
    end

endmodule

// File: rtl/pe_result_writer.sv
// Delays PE issue addresses by the pipeline latency, writes butterfly results
// back through two ports and tracks per-stage completion.
module pe_result_writer
    import pe_result_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sel_ntt,
    input  logic                  issue_valid,
    input  logic [addr_width-1:0] issue_addr_u,
    input  logic [addr_width-1:0] issue_addr_v,
    input  logic [data_width-1:0] bf_upper,
    input  logic [data_width-1:0] bf_lower,
    output logic                  wa_en,
    output logic [addr_width-1:0] wa_addr,
    output logic [data_width-1:0] wa_data,
    output logic                  wb_en,
    output logic [addr_width-1:0] wb_addr,
    output logic [data_width-1:0] wb_data,
    output logic                  busy,
    output logic                  stage_done,
    output logic                  issue_err
);

    delay_entry_t           issue_entry;
    delay_entry_t           head;
    logic [pe_lat-1:0]      valids;
    logic                   write;
    logic                   unused_mode;

    logic [cnt_width-1:0]   count;
    logic [cnt_width-1:0]   count_base;
    logic [cnt_width-1:0]   count_next;
    logic [lat_width-1:0]   in_flight;
    logic [cnt_width:0]     claimed;
    logic                   overflow;
    logic                   stage_done_next;
    logic                   issue_err_next;

    assign issue_entry = '{valid: issue_valid, addr_u: issue_addr_u,
                           addr_v: issue_addr_v, mode: sel_ntt};

    addr_delay_line #(
        .depth (pe_lat)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .din    (issue_entry),
        .head   (head),
        .valids (valids)
    );

    // Mode tag rides along for debug visibility only; routing ignores it.
    assign unused_mode = head.mode;

    assign write   = head.valid;
    assign wa_en   = write;
    assign wb_en   = write;
    assign wa_addr = write ? head.addr_u : '0;
    assign wb_addr = write ? head.addr_v : '0;
    assign wa_data = write ? bf_lower    : '0;
    assign wb_data = write ? bf_upper    : '0;

    // The head slot is being written this cycle, so it no longer counts as pending.
    assign busy = issue_valid | (|valids[pe_lat-2:0]);

    assign in_flight = count_valid(valids);

    always_comb begin
        count_base = start ? '0 : count;
        count_next = count_base;
        if (write && (count_base != cnt_width'(bf_per_stage))) begin
            count_next = count_base + cnt_width'(1);
        end
        stage_done_next = (count_next == cnt_width'(bf_per_stage))
                       && (count_base != cnt_width'(bf_per_stage));
        // Head entry is both in flight and not yet counted, so nothing is double-counted.
        claimed        = {1'b0, count_base} + (cnt_width+1)'(in_flight);
        overflow       = issue_valid && (claimed >= (cnt_width+1)'(bf_per_stage));
        issue_err_next = overflow | (issue_err & ~start);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            stage_done <= 1'b0;
            issue_err  <= 1'b0;
        end else begin
            count      <= count_next;
            stage_done <= stage_done_next;
            issue_err  <= issue_err_next;
        end
    end

endmodule

// File: tb/tb_pe_result_writer.sv
// Self-checking bench: per-cycle comparison against a history-based reference model.
module tb_pe_result_writer;
    import pe_result_writer_pkg::*;

    localparam int hist = 4096;

    logic                  clk = 1'b0;
    logic                  rst, start, sel_ntt, issue_valid;
    logic [addr_width-1:0] issue_addr_u, issue_addr_v;
    logic [data_width-1:0] bf_upper, bf_lower;
    logic                  wa_en, wb_en, busy, stage_done, issue_err;
    logic [addr_width-1:0] wa_addr, wb_addr;
    logic [data_width-1:0] wa_data, wb_data;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    bit   h_iv    [hist];
    bit   h_rst   [hist];
    bit   h_start [hist];
    logic [7:0] h_u [hist];
    logic [7:0] h_v [hist];

    int stage_writes = 0;
    bit m_done = 0;
    bit m_err  = 0;

    pe_result_writer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sel_ntt      (sel_ntt),
        .issue_valid  (issue_valid),
        .issue_addr_u (issue_addr_u),
        .issue_addr_v (issue_addr_v),
        .bf_upper     (bf_upper),
        .bf_lower     (bf_lower),
        .wa_en        (wa_en),
        .wa_addr      (wa_addr),
        .wa_data      (wa_data),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .busy         (busy),
        .stage_done   (stage_done),
        .issue_err    (issue_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // An issue at t is written at t+pe_lat unless a reset hit it while in flight.
    function automatic bit write_at(input int c);
        if (c < pe_lat) return 1'b0;
        if (!h_iv[c-pe_lat]) return 1'b0;
        for (int t = c - pe_lat; t < c; t++) begin
            if (h_rst[t]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit busy_exp(input int c);
        bit killed;
        for (int t = c - pe_lat + 1; t <= c; t++) begin
            if (t < 0) continue;
            if (!h_iv[t]) continue;
            killed = 1'b0;
            for (int k = t; k < c; k++) begin
                if (h_rst[k]) killed = 1'b1;
            end
            if (!killed) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        bit w;
        int inflight;
        int claimed;
        w = write_at(cyc);
        if (cyc >= 1) begin
            check_eq("wa_en",      wa_en, w);
            check_eq("wb_en",      wb_en, w);
            check_eq("wa_addr",    wa_addr, w ? h_u[cyc-pe_lat] : 8'h00);
            check_eq("wb_addr",    wb_addr, w ? h_v[cyc-pe_lat] : 8'h00);
            check_eq("wa_data",    wa_data, w ? bf_lower : 14'h0);
            check_eq("wb_data",    wb_data, w ? bf_upper : 14'h0);
            check_eq("busy",       busy, busy_exp(cyc));
            check_eq("stage_done", stage_done, m_done);
            check_eq("issue_err",  issue_err, m_err);
        end
        if (h_rst[cyc]) begin
            stage_writes = 0;
            m_err  = 0;
            m_done = 0;
        end else begin
            if (h_start[cyc]) stage_writes = 0;
            inflight = 0;
            for (int t = cyc - pe_lat; t < cyc; t++) begin
                if (t >= 0 && write_at(t + pe_lat)) inflight++;
            end
            claimed = ((stage_writes > bf_per_stage) ? bf_per_stage : stage_writes) + inflight;
            if (h_start[cyc]) m_err = 0;
            if (h_iv[cyc] && claimed >= bf_per_stage) m_err = 1;
            if (w) stage_writes++;
            m_done = w && (stage_writes == bf_per_stage);
        end
    end

    task automatic drive(input bit r, input bit s, input bit iv,
                         input logic [7:0] u, input logic [7:0] v);
        @(posedge clk);
        #1;
        if (cyc >= hist - pe_lat - 1) begin
            $display("FAIL history_overflow cyc=%0d limit=%0d", cyc, hist);
            $fatal(1, "history exhausted");
        end
        rst          = r;
        start        = s;
        issue_valid  = iv;
        issue_addr_u = u;
        issue_addr_v = v;
        sel_ntt      = 1'($urandom_range(0, 1));
        bf_lower     = 14'($urandom_range(0, 16383));
        bf_upper     = 14'($urandom_range(0, 16383));
        h_rst[cyc]   = r;
        h_start[cyc] = s;
        h_iv[cyc]    = iv;
        h_u[cyc]     = u;
        h_v[cyc]     = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic issue_rand(input bit s);
        drive(0, s, 1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    initial begin
        rst = 1; start = 0; sel_ntt = 0; issue_valid = 0;
        issue_addr_u = '0; issue_addr_v = '0; bf_lower = '0; bf_upper = '0;
        h_rst[0] = 1;

        // reset then single issue at cycle 10, written at cycle 16
        drive(1, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 8'h00, 8'h00);
        idle(7);
        drive(0, 0, 1, 8'h03, 8'h83);
        #3 check_eq("t1_issue_cycle", cyc, 10);
        check_eq("t1_busy_at_issue", busy, 1);
        idle(5);
        drive(0, 0, 0, 8'h00, 8'h00);
        bf_lower = 14'h1234;
        bf_upper = 14'h0ABC;
        #3 check_eq("t1_wa_addr", wa_addr, 8'h03);
        check_eq("t1_wa_data", wa_data, 14'h1234);
        check_eq("t1_wb_addr", wb_addr, 8'h83);
        check_eq("t1_wb_data", wb_data, 14'h0ABC);
        check_eq("t1_busy_at_write", busy, 0);
        idle(4);

        // full stage of back-to-back issues
        drive(0, 1, 0, 8'h00, 8'h00);
        for (int i = 0; i < bf_per_stage; i++) issue_rand(0);
        idle(10);

        // gapped issues, one every third cycle
        drive(0, 1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            issue_rand(0);
            idle(2);
        end
        idle(8);

        // reset with butterflies in flight
        for (int i = 0; i < 4; i++) issue_rand(0);
        idle(2);
        drive(1, 0, 0, 8'h00, 8'h00);
        idle(1);
        #3 check_eq("t4_busy_after_rst", busy, 0);
        idle(8);

        // start with two in flight, then 254 new issues
        issue_rand(0);
        issue_rand(0);
        issue_rand(1);
        for (int i = 1; i < bf_per_stage - 2; i++) issue_rand(0);
        idle(10);

        // overflow: 257 issues in one stage
        drive(0, 1, 0, 8'h00, 8'h00);
        for (int i = 0; i < bf_per_stage + 1; i++) issue_rand(0);
        idle(12);
        #3 check_eq("t6_err_sticky", issue_err, 1);
        drive(0, 1, 0, 8'h00, 8'h00);
        idle(1);
        #3 check_eq("t6_err_cleared", issue_err, 0);

        // randomized traffic with occasional start and reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 127) == 0)
                drive(1, 0, 0, 8'h00, 8'h00);
            else
                drive(0, ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
